// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The sequencer walks the operands one nibble per cycle.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned num_nibbles(input int unsigned width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/ripple_Adder.sv
// 4-bit ripple-carry adder used as the datapath of the nibble-serial adder.
// Port names are kept from the existing block.
module ripple_Adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    S    = '0;
    c    = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder computing four bits per cycle through a single 4-bit ripple adder,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N    = num_nibbles(WIDTH);
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NIBBLE-1:0] add_s;
  logic              add_c;

  ripple_Adder u_ripple_adder (
    .x    (a_q[NIBBLE-1:0]),
    .y    (b_q[NIBBLE-1:0]),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_c)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Sum nibbles enter at the top so the first one lands at bits 3:0 after N shifts.
        res_d   = {add_s, res_q[WIDTH-1:NIBBLE]};
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        carry_d = add_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = res_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus a randomized
// handshake run scored against plain a+b+cin arithmetic.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;

  nibble_serial_adder #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  // Called #1 after an edge with the block idle. Scrambles a/b/in_valid while running and,
  // when hold > 0, applies back-pressure for that many cycles while offering new operands.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2, input logic tc,
                        input int hold, input string tag);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    int               edges;
    exp = ref_add(ta, tb2, tc);
    check({tag, "_idle_ready"}, (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    a         = ta;
    b         = tb2;
    cin       = tc;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    edges = 0;
    while (!out_valid && edges < 20) begin
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, (WIDTH+1)'(edges), (WIDTH+1)'(4));
    check({tag, "_result"}, {cout, sum}, exp);
    held_sum  = sum;
    held_cout = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = ~ta;
      b        = WIDTH'($urandom);
      cin      = ~tc;
      @(posedge clk); #1;
      check({tag, "_hold_result"}, {cout, sum}, {held_cout, held_sum});
      check({tag, "_hold_valid"}, (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
      check({tag, "_hold_busy"}, (WIDTH+1)'(in_ready), (WIDTH+1)'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_post_valid"}, (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    check({tag, "_post_ready"}, (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    @(posedge clk); #1;
    check({tag, "_no_second_op"}, (WIDTH+1)'({out_valid, in_ready}), (WIDTH+1)'(1));
  endtask

  initial begin
    logic [WIDTH:0] q[$];
    logic [WIDTH:0] e;
    int n_in;
    int n_out;
    checks    = 0;
    errors    = 0;
    n_in      = 0;
    n_out     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #2;
    check("reset_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    check("reset_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    check("reset_result", {cout, sum}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "carry_chain");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "all_ones");
    run_op(16'hA5C3, 16'h1F0E, 1'b1, 5, "backpressure");

    // Abort mid-operation with an asynchronous reset.
    check("abort_idle_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    a        = 16'h7777;
    b        = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    check("abort_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h8000, 16'h8000, 1'b0, 0, "after_abort");

    // Randomized traffic: outputs checked on the cycle the result handshake is offered.
    for (int cyc = 0; cyc < 30000 && n_out < 1000; cyc++) begin
      if (out_valid) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (out_ready) begin
          if (q.size() == 0) begin
            check("rand_unexpected_result", {cout, sum}, '0);
          end else begin
            e = q.pop_front();
            check("rand_result", {cout, sum}, e);
          end
          n_out++;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      in_valid = ($urandom_range(0, 9) < 7);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      if (in_valid && in_ready) begin
        q.push_back(ref_add(a, b, cin));
        n_in++;
      end
      @(posedge clk); #1;
    end
    check("rand_enough_ops", (WIDTH+1)'(n_out >= 1000), (WIDTH+1)'(1));

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      if (out_valid) begin
        e = q.pop_front();
        check("drain_result", {cout, sum}, e);
        n_out++;
      end
      @(posedge clk); #1;
    end
    check("rand_op_count", (WIDTH+1)'(n_out), (WIDTH+1)'(n_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
